// File: rtl/cnn_window_pkg.sv
// Shared sizing helpers for the sliding window generator and its row FIFOs.
package cnn_window_pkg;

   // Width of a counter that must hold values 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a stride phase counter holding 0..stride-1.
   function automatic int phase_width(input int stride);
      return $clog2(stride) + 1;
   endfunction

   function automatic int pix_bits(input int channels, input int data_width);
      return channels * data_width;
   endfunction

   function automatic int win_bits(input int k, input int channels, input int data_width);
      return k * k * channels * data_width;
   endfunction

endpackage

// File: rtl/row_fifo.sv
// One image row of delay: a circular RAM with a single pointer.
// The slot under the pointer is read (oldest pixel) and then overwritten
// with the incoming pixel on the same enabled edge.
module row_fifo
   import cnn_window_pkg::*;
#(
   parameter int DEPTH = 28,
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             sreset,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   localparam int                PTR_W    = cnt_width(DEPTH);
   localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] ptr;

   assign dout = mem[ptr];

   // Pointer walks the ring once per row; contents are left untouched by reset.
   always_ff @(posedge clock) begin
      if (sreset) begin
         ptr <= '0;
      end else if (en) begin
         ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
      end
   end

   // Write the new pixel into the slot just read.
   always_ff @(posedge clock) begin
      if (en) begin
         mem[ptr] <= din;
      end
   end

endmodule

// File: rtl/sliding_window_buffer.sv
// Streaming K x K x CHANNELS window generator. K-1 cascaded row FIFOs supply
// the pixels directly above the incoming one; the window shifts left one
// column per accepted pixel. Stride phases are down-counters that reload at
// the first window column/row, so no divide or modulo is needed.
module sliding_window_buffer
   import cnn_window_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int CHANNELS    = 1,
   parameter int KERNEL_SIZE = 3,
   parameter int ROW_SIZE    = 28,
   parameter int COL_SIZE    = 28,
   parameter int STRIDE      = 1
) (
   input  logic                                                   clock,
   input  logic                                                   sreset,
   input  logic                                                   data_valid,
   input  logic [CHANNELS*DATA_WIDTH-1:0]                         data_in,
   output logic [KERNEL_SIZE*KERNEL_SIZE*CHANNELS*DATA_WIDTH-1:0] window_out,
   output logic                                                   window_valid,
   output logic                                                   frame_done
);

   localparam int K        = KERNEL_SIZE;
   localparam int PIX_BITS = pix_bits(CHANNELS, DATA_WIDTH);
   localparam int WIN_BITS = win_bits(K, CHANNELS, DATA_WIDTH);
   localparam int COL_W    = cnt_width(ROW_SIZE);
   localparam int ROW_W    = cnt_width(COL_SIZE);
   localparam int PH_W     = phase_width(STRIDE);

   localparam logic [COL_W-1:0] COL_LAST      = COL_W'(ROW_SIZE - 1);
   localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(K - 1);
   localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(COL_SIZE - 1);
   localparam logic [ROW_W-1:0] ROW_FIRST_WIN = ROW_W'(K - 1);
   localparam logic [PH_W-1:0]  PH_RELOAD     = PH_W'(STRIDE - 1);

   logic                accept;
   logic [PIX_BITS-1:0] fifo_in  [K-1];
   logic [PIX_BITS-1:0] fifo_out [K-1];
   logic [PIX_BITS-1:0] new_col  [K];
   logic [PIX_BITS-1:0] win      [K][K];

   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [PH_W-1:0]  col_ph;
   logic [PH_W-1:0]  row_ph;
   logic             col_wrap;
   logic             row_wrap;
   logic             col_ph_zero;
   logic             row_ph_zero;
   logic             win_pos;

   assign accept = data_valid && !sreset;

   // Row delay chain: FIFO j delivers the pixel j+1 rows above the input.
   for (genvar j = 0; j < K - 1; j++) begin : g_fifo
      if (j == 0) begin : g_head
         assign fifo_in[j] = data_in;
      end else begin : g_tail
         assign fifo_in[j] = fifo_out[j-1];
      end

      row_fifo #(
         .DEPTH (ROW_SIZE),
         .WIDTH (PIX_BITS)
      ) u_row_fifo (
         .clock  (clock),
         .sreset (sreset),
         .en     (accept),
         .din    (fifo_in[j]),
         .dout   (fifo_out[j])
      );
   end

   // Incoming column, top (oldest row) to bottom (current pixel).
   for (genvar r = 0; r < K; r++) begin : g_col
      if (r == K - 1) begin : g_bottom
         assign new_col[r] = data_in;
      end else begin : g_upper
         assign new_col[r] = fifo_out[K-2-r];
      end
   end

   // Flatten window: element (r,c) at pixel slot r*K+c, channels packed as in data_in.
   for (genvar r = 0; r < K; r++) begin : g_out_r
      for (genvar c = 0; c < K; c++) begin : g_out_c
         assign window_out[(r*K + c)*PIX_BITS +: PIX_BITS] = win[r][c];
      end
   end

   // Window registers shift left one column per accepted pixel.
   always_ff @(posedge clock) begin
      if (sreset) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
               win[r][c] <= '0;
            end
         end
      end else if (accept) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
               win[r][c] <= win[r][c+1];
            end
            win[r][K-1] <= new_col[r];
         end
      end
   end

   // A phase is "zero" at the first window position or when its countdown expires.
   assign col_wrap    = (col == COL_LAST);
   assign row_wrap    = (row == ROW_LAST);
   assign col_ph_zero = (col == COL_FIRST_WIN) || (col_ph == '0);
   assign row_ph_zero = (row == ROW_FIRST_WIN) || (row_ph == '0);
   assign win_pos     = (row >= ROW_FIRST_WIN) && (col >= COL_FIRST_WIN) &&
                        col_ph_zero && row_ph_zero;

   // Raster position, stride phases and the registered strobes.
   always_ff @(posedge clock) begin
      if (sreset) begin
         col          <= '0;
         row          <= '0;
         col_ph       <= '0;
         row_ph       <= '0;
         window_valid <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         window_valid <= accept && win_pos;
         frame_done   <= accept && col_wrap && row_wrap;
         if (accept) begin
            col    <= col_wrap ? '0 : col + 1'b1;
            col_ph <= col_ph_zero ? PH_RELOAD : col_ph - 1'b1;
            if (col_wrap) begin
               row    <= row_wrap ? '0 : row + 1'b1;
               row_ph <= row_ph_zero ? PH_RELOAD : row_ph - 1'b1;
            end
         end
      end
   end

   // WIN_BITS documents the flattened width; tie it to the port so a mismatch is caught early.
   if (WIN_BITS != $bits(window_out)) begin : g_bad_width
      $error("window width mismatch");
   end

endmodule

// File: tb/tb_sliding_window_buffer.sv
// Bench for sliding_window_buffer: three configurations share one stimulus
// stream and are checked against a frame-image reference model.
module tb_sliding_window_buffer;

   logic         clock = 1'b0;
   logic         sreset = 1'b1;
   logic         data_valid = 1'b0;
   logic [15:0]  din_a = '0;
   logic [7:0]   din_b = '0;
   logic [7:0]   din_c = '0;
   logic [143:0] win_a;
   logic [71:0]  win_b;
   logic [31:0]  win_c;
   logic         wv_a, fd_a, wv_b, fd_b, wv_c, fd_c;

   int n_checks = 0;
   int n_fail   = 0;

   // Per-instance configuration: A (K3 5x5 2ch s1), B (K3 5x5 1ch s2), C (K2 6x4 1ch s3).
   int kk  [3] = '{3, 3, 2};
   int rs  [3] = '{5, 5, 6};
   int cs  [3] = '{5, 5, 4};
   int st  [3] = '{1, 2, 3};
   int chn [3] = '{2, 1, 1};

   int img [3][8][8];
   int mr [3];
   int mc [3];
   int dut_cnt [3];

   int first_w [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
   int last_w  [9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};

   always #5 clock = ~clock;

   sliding_window_buffer #(
      .DATA_WIDTH(8), .CHANNELS(2), .KERNEL_SIZE(3), .ROW_SIZE(5), .COL_SIZE(5), .STRIDE(1)
   ) u_dut_a (
      .clock(clock), .sreset(sreset), .data_valid(data_valid), .data_in(din_a),
      .window_out(win_a), .window_valid(wv_a), .frame_done(fd_a)
   );

   sliding_window_buffer #(
      .DATA_WIDTH(8), .CHANNELS(1), .KERNEL_SIZE(3), .ROW_SIZE(5), .COL_SIZE(5), .STRIDE(2)
   ) u_dut_b (
      .clock(clock), .sreset(sreset), .data_valid(data_valid), .data_in(din_b),
      .window_out(win_b), .window_valid(wv_b), .frame_done(fd_b)
   );

   sliding_window_buffer #(
      .DATA_WIDTH(8), .CHANNELS(1), .KERNEL_SIZE(2), .ROW_SIZE(6), .COL_SIZE(4), .STRIDE(3)
   ) u_dut_c (
      .clock(clock), .sreset(sreset), .data_valid(data_valid), .data_in(din_c),
      .window_out(win_c), .window_valid(wv_c), .frame_done(fd_c)
   );

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Expected window at (r,c): the K x K block of the frame image ending there.
   function automatic logic [255:0] exp_win(input int n, input int r, input int c);
      logic [255:0] w = '0;
      int k = kk[n];
      int v;
      for (int i = 0; i < k; i++)
         for (int j = 0; j < k; j++)
            for (int ch = 0; ch < chn[n]; ch++) begin
               v = img[n][r-k+1+i][c-k+1+j] + 100*ch;
               w[((i*k + j)*chn[n] + ch)*8 +: 8] = v[7:0];
            end
      return w;
   endfunction

   function automatic int elem_a(input int r, input int c, input int ch);
      return int'(win_a[((r*3 + c)*2 + ch)*8 +: 8]);
   endfunction

   // One clock: drive at negedge, predict from the model, check after the edge.
   task automatic step(input bit v, input bit rst, input int pix);
      bit           ev [3];
      bit           ef [3];
      logic [255:0] ew [3];
      int           r, c, k;
      @(negedge clock);
      sreset     = rst;
      data_valid = v;
      din_a      = {8'(pix + 100), 8'(pix)};
      din_b      = 8'(pix);
      din_c      = 8'(pix);
      for (int n = 0; n < 3; n++) begin
         ev[n] = 1'b0;
         ef[n] = 1'b0;
         ew[n] = '0;
         if (rst) begin
            mr[n] = 0;
            mc[n] = 0;
         end else if (v) begin
            r = mr[n];
            c = mc[n];
            k = kk[n];
            img[n][r][c] = pix;
            ev[n] = (r >= k-1) && (c >= k-1) &&
                    ((r - (k-1)) % st[n] == 0) && ((c - (k-1)) % st[n] == 0);
            ef[n] = (r == cs[n]-1) && (c == rs[n]-1);
            if (ev[n]) ew[n] = exp_win(n, r, c);
            c++;
            if (c == rs[n]) begin
               c = 0;
               r++;
               if (r == cs[n]) r = 0;
            end
            mr[n] = r;
            mc[n] = c;
         end
      end
      @(posedge clock);
      #1;
      check_eq("valid_a", wv_a, ev[0]);
      check_eq("done_a",  fd_a, ef[0]);
      check_eq("valid_b", wv_b, ev[1]);
      check_eq("done_b",  fd_b, ef[1]);
      check_eq("valid_c", wv_c, ev[2]);
      check_eq("done_c",  fd_c, ef[2]);
      if (ev[0]) check_eq("window_a", win_a, ew[0]);
      if (ev[1]) check_eq("window_b", win_b, ew[1]);
      if (ev[2]) check_eq("window_c", win_c, ew[2]);
      if (wv_a) dut_cnt[0]++;
      if (wv_b) dut_cnt[1]++;
      if (wv_c) dut_cnt[2]++;
   endtask

   task automatic clear_counts();
      for (int n = 0; n < 3; n++) dut_cnt[n] = 0;
   endtask

   initial begin
      // Reset state.
      step(1'b0, 1'b1, 0);
      step(1'b0, 1'b1, 0);
      check_eq("reset_win_a", win_a, '0);
      check_eq("reset_win_b", win_b, '0);
      check_eq("reset_win_c", win_c, '0);

      // Frame 1: ramp with data_valid held high.
      clear_counts();
      for (int i = 0; i < 25; i++) begin
         step(1'b1, 1'b0, i);
         if (i == 12) begin
            check_eq("first_window_strobe", wv_a, 1'b1);
            for (int e = 0; e < 9; e++) begin
               check_eq("first_win_ch0", elem_a(e/3, e%3, 0), first_w[e]);
               check_eq("first_win_ch1", elem_a(e/3, e%3, 1), first_w[e] + 100);
            end
         end
         if (i == 24) begin
            check_eq("last_done_a", fd_a, 1'b1);
            for (int e = 0; e < 9; e++)
               check_eq("last_win_ch0", elem_a(e/3, e%3, 0), last_w[e]);
         end
      end
      check_eq("count_f1_a", dut_cnt[0], 9);
      check_eq("count_f1_b", dut_cnt[1], 4);
      check_eq("count_f1_c", dut_cnt[2], 2);

      // Frame 2: ramp continues, data_valid low every third cycle.
      clear_counts();
      begin
         int i = 25;
         int cyc = 0;
         while (i < 50) begin
            if (cyc % 3 == 2) step(1'b0, 1'b0, int'($urandom_range(0, 255)));
            else begin
               step(1'b1, 1'b0, i);
               i++;
            end
            cyc++;
         end
      end
      check_eq("count_f2_a", dut_cnt[0], 9);
      check_eq("count_f2_b", dut_cnt[1], 4);

      // Reset after pixel 17 of a frame, then a fresh ramp.
      for (int i = 0; i < 18; i++) step(1'b1, 1'b0, i);
      step(1'b1, 1'b1, 99);
      clear_counts();
      for (int i = 0; i < 25; i++) begin
         step(1'b1, 1'b0, i);
         if (i == 11) check_eq("no_early_window", dut_cnt[0], 0);
      end
      check_eq("count_rst_a", dut_cnt[0], 9);
      check_eq("count_rst_b", dut_cnt[1], 4);
      check_eq("count_rst_c", dut_cnt[2], 2);

      // Random pixels, random valid gaps, rare resets.
      for (int t = 0; t < 600; t++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0,
              int'($urandom_range(0, 255)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
